// File: rtl/dp_sink_unpack_pkg.sv
// Shared DisplayPort main-link definitions: K-symbol codes, link region states
// and the per-byte context that is threaded through the depacketizer chain.
package dp_sink_unpack_pkg;

   localparam logic [7:0] SYM_BS = 8'hBC;   // blanking start
   localparam logic [7:0] SYM_BE = 8'hFB;   // blanking end
   localparam logic [7:0] SYM_FS = 8'hFE;   // fill start
   localparam logic [7:0] SYM_FE = 8'hF7;   // fill end

   typedef enum logic [1:0] {
      ST_BLANK      = 2'd0,
      ST_BLANK_VBID = 2'd1,
      ST_DATA       = 2'd2,
      ST_FILL       = 2'd3
   } dp_state_e;

   // Context carried from one byte to the next: region, bytes already held
   // for the current pixel, and the partially assembled pixel.
   typedef struct packed {
      dp_state_e   st;
      logic [1:0]  rem;
      logic [23:0] acc;
   } dp_ctx_t;

endpackage

// File: rtl/dp_sink_byte.sv
// One combinational depacketizer step for a single symbol. Four of these are
// chained to process a 32-bit link word in byte order.
module dp_sink_byte
   import dp_sink_unpack_pkg::*;
(
   input  dp_ctx_t     cin,
   input  logic [7:0]  sym,
   input  logic        k,
   output dp_ctx_t     cout,
   output logic        pdone,
   output logic [23:0] pix,
   output logic        err,
   output logic        be,
   output logic        vbld
);

   // Decode one symbol: K codes steer the region, data bytes fill the pixel.
   always_comb begin
      cout  = cin;
      pdone = 1'b0;
      pix   = cin.acc;
      err   = 1'b0;
      be    = 1'b0;
      vbld  = 1'b0;
      if (k) begin
         case (sym)
            SYM_BS: begin
               // a pixel cut short by blanking is discarded
               err      = (cin.rem != 2'd0);
               cout.rem = 2'd0;
               cout.acc = 24'd0;
               cout.st  = ST_BLANK_VBID;
            end
            SYM_BE: begin
               err     = (cin.st != ST_BLANK);
               cout.st = ST_DATA;
               be      = 1'b1;
            end
            SYM_FS: begin
               err     = (cin.st != ST_DATA);
               cout.st = ST_FILL;
            end
            SYM_FE: begin
               err     = (cin.st != ST_FILL);
               cout.st = ST_DATA;
            end
            default: err = 1'b1;
         endcase
      end else begin
         case (cin.st)
            ST_BLANK_VBID: begin
               vbld    = 1'b1;
               cout.st = ST_BLANK;
            end
            ST_DATA: begin
               case (cin.rem)
                  2'd0: begin
                     cout.acc[23:16] = sym;
                     cout.rem        = 2'd1;
                  end
                  2'd1: begin
                     cout.acc[15:8] = sym;
                     cout.rem       = 2'd2;
                  end
                  default: begin
                     cout.acc[7:0] = sym;
                     cout.rem      = 2'd0;
                     pix           = {cin.acc[23:8], sym};
                     pdone         = 1'b1;
                  end
               endcase
            end
            default: ;  // blanking and fill bytes carry no pixel data
         endcase
      end
   end

endmodule

// File: rtl/dp_sink_unpack.sv
// Sink-side main-link depacketizer: turns 4-symbol link words into up to two
// RGB pixels per cycle with coordinates, line start and vertical blank status.
module dp_sink_unpack
   import dp_sink_unpack_pkg::*;
#(
   parameter int XBITS = 12,
   parameter int YBITS = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      data,
   input  logic [3:0]       isk,
   output logic [23:0]      pix0,
   output logic [23:0]      pix1,
   output logic [1:0]       pixvalid,
   output logic [XBITS-1:0] pixx,
   output logic [YBITS-1:0] pixy,
   output logic             linestart,
   output logic             vblank,
   output logic             err
);

   dp_ctx_t          ctx_q, ctx1, ctx2, ctx3, ctx4;
   logic [XBITS-1:0] x_q, cx, n_x;
   logic [YBITS-1:0] y_q, cy, n_y;
   logic             lp_q, clp, cvb, got;
   logic [3:0]       pd, be, berr, vbld;
   logic [23:0]      bpix [4];
   logic [23:0]      n_p0, n_p1;
   logic [1:0]       n_pv;
   logic             n_ls, n_err;

   // Byte chain; each step sees the context left by the previous byte.
   dp_sink_byte u_b0 (.cin(ctx_q), .sym(data[7:0]),   .k(isk[0]), .cout(ctx1),
                      .pdone(pd[0]), .pix(bpix[0]), .err(berr[0]), .be(be[0]), .vbld(vbld[0]));
   dp_sink_byte u_b1 (.cin(ctx1),  .sym(data[15:8]),  .k(isk[1]), .cout(ctx2),
                      .pdone(pd[1]), .pix(bpix[1]), .err(berr[1]), .be(be[1]), .vbld(vbld[1]));
   dp_sink_byte u_b2 (.cin(ctx2),  .sym(data[23:16]), .k(isk[2]), .cout(ctx3),
                      .pdone(pd[2]), .pix(bpix[2]), .err(berr[2]), .be(be[2]), .vbld(vbld[2]));
   dp_sink_byte u_b3 (.cin(ctx3),  .sym(data[31:24]), .k(isk[3]), .cout(ctx4),
                      .pdone(pd[3]), .pix(bpix[3]), .err(berr[3]), .be(be[3]), .vbld(vbld[3]));

   // Walk the four byte results in order to update position, blanking and
   // the two pixel slots.
   always_comb begin
      cx    = x_q;
      cy    = y_q;
      cvb   = vblank;
      clp   = lp_q;
      n_pv  = 2'b00;
      n_p0  = 24'd0;
      n_p1  = 24'd0;
      n_x   = x_q;
      n_y   = y_q;
      n_ls  = 1'b0;
      n_err = |berr;
      got   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (isk[i] && data[8*i +: 8] == SYM_BS) begin
            // only an active line that produced pixels advances y
            if (clp && !cvb) cy = cy + 1'b1;
            clp = 1'b0;
         end
         if (be[i]) begin
            cx   = '0;
            n_ls = 1'b1;
         end
         if (vbld[i]) begin
            cvb = data[8*i];
            if (data[8*i]) cy = '0;
         end
         if (pd[i]) begin
            if (!n_pv[0]) begin
               n_p0    = bpix[i];
               n_pv[0] = 1'b1;
               n_x     = cx;
            end else begin
               n_p1    = bpix[i];
               n_pv[1] = 1'b1;
            end
            n_y = cy;
            got = 1'b1;
            cx  = cx + 1'b1;
            clp = 1'b1;
         end
      end
      if (!n_pv[0]) n_x = cx;
      if (!got)     n_y = cy;
   end

   // Register link context and all outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctx_q     <= '{st: ST_BLANK, rem: 2'd0, acc: 24'd0};
         x_q       <= '0;
         y_q       <= '0;
         lp_q      <= 1'b0;
         vblank    <= 1'b1;
         pix0      <= 24'd0;
         pix1      <= 24'd0;
         pixvalid  <= 2'b00;
         pixx      <= '0;
         pixy      <= '0;
         linestart <= 1'b0;
         err       <= 1'b0;
      end else begin
         ctx_q     <= ctx4;
         x_q       <= cx;
         y_q       <= cy;
         lp_q      <= clp;
         vblank    <= cvb;
         pix0      <= n_p0;
         pix1      <= n_p1;
         pixvalid  <= n_pv;
         pixx      <= n_x;
         pixy      <= n_y;
         linestart <= n_ls;
         err       <= n_err;
      end
   end

endmodule

// File: tb/tb_dp_sink_unpack.sv
// Bench for dp_sink_unpack: directed scenarios plus random link words, each
// checked against a byte-stream reference model kept in the bench.
module tb_dp_sink_unpack;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data;
   logic [3:0]  isk;
   logic [23:0] pix0, pix1;
   logic [1:0]  pixvalid;
   logic [11:0] pixx, pixy;
   logic        linestart, vblank, err;

   int tests = 0;
   int fails = 0;

   dp_sink_unpack #(.XBITS(12), .YBITS(12)) dut (
      .clk(clk), .reset(reset), .data(data), .isk(isk),
      .pix0(pix0), .pix1(pix1), .pixvalid(pixvalid), .pixx(pixx), .pixy(pixy),
      .linestart(linestart), .vblank(vblank), .err(err)
   );

   always #5 clk = ~clk;

   // Observed outputs; coordinates only matter when a pixel is reported.
   logic [76:0] obs;
   assign obs = {pixvalid, pix0, pix1, (pixvalid != 2'b00) ? pixx : 12'd0,
                 (pixvalid != 2'b00) ? pixy : 12'd0, linestart, vblank, err};

   // Reference model: link region, pending data bytes, position, blank flag.
   localparam int M_BLANK = 0, M_VBID = 1, M_DATA = 2, M_FILL = 3;
   int          m_st;
   logic [7:0]  part [$];
   logic [11:0] m_x, m_y;
   logic        m_vb, m_lp;
   logic [76:0] expv;

   function automatic logic [31:0] w(input logic [7:0] b0, b1, b2, b3);
      return {b3, b2, b1, b0};
   endfunction

   task automatic model_reset();
      m_st = M_BLANK; part.delete(); m_x = 0; m_y = 0; m_vb = 1'b1; m_lp = 1'b0;
   endtask

   task automatic model_word(input logic [31:0] d, input logic [3:0] k);
      logic [7:0]  b;
      logic [23:0] p0, p1, px;
      logic [11:0] fx, fy;
      logic        ls, er;
      int          np;
      p0 = 0; p1 = 0; fx = 0; fy = 0; ls = 0; er = 0; np = 0;
      for (int i = 0; i < 4; i++) begin
         b = d[8*i +: 8];
         if (k[i]) begin
            if (b == 8'hBC) begin
               if (part.size() != 0) er = 1;
               part.delete();
               if (m_lp && !m_vb) m_y++;
               m_lp = 0; m_st = M_VBID;
            end else if (b == 8'hFB) begin
               if (m_st != M_BLANK) er = 1;
               m_st = M_DATA; m_x = 0; ls = 1;
            end else if (b == 8'hFE) begin
               if (m_st != M_DATA) er = 1;
               m_st = M_FILL;
            end else if (b == 8'hF7) begin
               if (m_st != M_FILL) er = 1;
               m_st = M_DATA;
            end else er = 1;
         end else if (m_st == M_VBID) begin
            m_vb = b[0];
            if (b[0]) m_y = 0;
            m_st = M_BLANK;
         end else if (m_st == M_DATA) begin
            part.push_back(b);
            if (part.size() == 3) begin
               px = {part[0], part[1], part[2]};
               part.delete();
               if (np == 0) begin p0 = px; fx = m_x; end else p1 = px;
               np++; fy = m_y; m_x++; m_lp = 1;
            end
         end
      end
      expv = {(np == 0) ? 2'b00 : (np == 1) ? 2'b01 : 2'b11, p0, p1,
              fx, fy, ls, m_vb, er};
   endtask

   task automatic do_reset();
      reset = 1'b1; data = 0; isk = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] k);
      @(negedge clk);
      data = d; isk = k;
      model_word(d, k);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests++;
      if ({pixvalid, pix0, pix1, pixx, pixy, linestart, err} !== 77'd0 || vblank !== 1'b1) begin
         fails++;
         $display("FAIL reset: got %h vb=%b, want all zero vb=1", obs, vblank);
      end
   endtask

   task automatic test_basic();
      logic [31:0] ws [5];
      do_reset();
      ws[0] = w(8'hFB, 8'hFF, 8'h00, 8'hFF);
      ws[1] = w(8'hFF, 8'h00, 8'hFF, 8'hFF);
      ws[2] = w(8'h00, 8'hFF, 8'hFF, 8'h00);
      ws[3] = w(8'hFF, 8'hFF, 8'h00, 8'hFF);
      ws[4] = w(8'hFF, 8'h00, 8'hFF, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         send(ws[i], (i == 0) ? 4'b0001 : 4'b0000);
         tests++;
         if (obs !== expv) begin
            fails++; $display("FAIL basic w%0d: got %h want %h", i, obs, expv);
         end
         if (i == 0) begin
            tests++;
            if ({linestart, pixvalid, pix0, pixx, pixy} !== {1'b1, 2'b01, 24'hFF00FF, 24'd0}) begin
               fails++;
               $display("FAIL basic_first: got ls=%b pv=%b p0=%h x=%0d y=%0d", linestart, pixvalid, pix0, pixx, pixy);
            end
         end
         if (i == 3) begin
            tests++;
            if ({pixvalid, pixx, pix0, pix1} !== {2'b11, 12'd3, 24'hFF00FF, 24'hFF00FF}) begin
               fails++;
               $display("FAIL basic_two: got pv=%b x=%0d p0=%h p1=%h, want 11 3 ff00ff ff00ff", pixvalid, pixx, pix0, pix1);
            end
         end
      end
   endtask

   task automatic test_two_pix();
      do_reset();
      send(w(8'hFB, 8'h01, 8'h02, 8'h03), 4'b0001);
      send(w(8'hFE, 8'hF7, 8'hAA, 8'hBB), 4'b0011);
      tests++;
      if (obs !== expv) begin fails++; $display("FAIL two_pix_pre: got %h want %h", obs, expv); end
      send(w(8'h11, 8'h22, 8'h33, 8'h44), 4'b0000);
      tests++;
      if ({pixvalid, pix0, pix1, pixx, err} !== {2'b11, 24'hAABB11, 24'h223344, 12'd1, 1'b0}) begin
         fails++;
         $display("FAIL two_pix: got pv=%b p0=%h p1=%h x=%0d err=%b, want 11 aabb11 223344 1 0", pixvalid, pix0, pix1, pixx, err);
      end
   endtask

   task automatic test_fill();
      do_reset();
      send(w(8'hFB, 8'hAA, 8'hBB, 8'hFE), 4'b1001);
      send(w(8'h12, 8'h34, 8'h56, 8'hF7), 4'b1000);
      tests++;
      if (obs !== expv || err !== 1'b0 || pixvalid !== 2'b00) begin
         fails++; $display("FAIL fill_mid: got %h want %h", obs, expv);
      end
      send(w(8'hCC, 8'hFE, 8'h99, 8'h98), 4'b0010);
      tests++;
      if ({pixvalid, pix0, pixx, err} !== {2'b01, 24'hAABBCC, 12'd0, 1'b0}) begin
         fails++;
         $display("FAIL fill: got pv=%b p0=%h x=%0d err=%b, want 01 aabbcc 0 0", pixvalid, pix0, pixx, err);
      end
   endtask

   task automatic test_bs_partial();
      do_reset();
      send(w(8'hFB, 8'hAA, 8'hBC, 8'h00), 4'b0101);
      tests++;
      if ({err, pixvalid, vblank} !== {1'b1, 2'b00, 1'b0} || obs !== expv) begin
         fails++; $display("FAIL bs_partial: got err=%b pv=%b vb=%b, want 1 00 0", err, pixvalid, vblank);
      end
      send(w(8'hFB, 8'h11, 8'h22, 8'h33), 4'b0001);
      tests++;
      if ({err, linestart, pixvalid, pix0, pixx} !== {1'b0, 1'b1, 2'b01, 24'h112233, 12'd0}) begin
         fails++;
         $display("FAIL bs_clean: got err=%b ls=%b pv=%b p0=%h x=%0d, want 0 1 01 112233 0", err, linestart, pixvalid, pix0, pixx);
      end
   endtask

   task automatic test_vblank();
      logic [7:0] q;
      do_reset();
      send(w(8'hBC, 8'h01, 8'h00, 8'h00), 4'b0001);
      tests++;
      if ({vblank, err} !== 2'b10) begin
         fails++; $display("FAIL vblank_set: got vb=%b err=%b, want 1 0", vblank, err);
      end
      for (int l = 0; l < 3; l++) begin
         q = 8'(8'h40 + l);
         send(w(8'hBC, 8'h00, 8'hFB, q), 4'b0101);
         send(w(q, q, 8'hFE, 8'hF7), 4'b1100);
         tests++;
         if ({pixvalid, pixy, pix0, vblank, err} !== {2'b01, 12'(l), {q, q, q}, 1'b0, 1'b0} || obs !== expv) begin
            fails++;
            $display("FAIL vblank_line%0d: got pv=%b y=%0d p0=%h vb=%b err=%b", l, pixvalid, pixy, pix0, vblank, err);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] ws [6];
      logic [3:0]  ks [6];
      logic        we [6];
      do_reset();
      ws[0] = w(8'hFE, 8'h00, 8'h00, 8'h00); ks[0] = 4'b0001; we[0] = 1; // FS in blank
      ws[1] = w(8'h1C, 8'h00, 8'h00, 8'h00); ks[1] = 4'b0001; we[1] = 1; // unknown K
      ws[2] = w(8'hBC, 8'h00, 8'hFB, 8'h11); ks[2] = 4'b0101; we[2] = 0;
      ws[3] = w(8'h22, 8'h33, 8'hF7, 8'h00); ks[3] = 4'b0100; we[3] = 1; // FE in data
      ws[4] = w(8'h44, 8'h55, 8'hFB, 8'h66); ks[4] = 4'b0100; we[4] = 1; // BE in data
      ws[5] = w(8'h77, 8'h88, 8'hFE, 8'hF7); ks[5] = 4'b1100; we[5] = 0;
      for (int i = 0; i < 6; i++) begin
         send(ws[i], ks[i]);
         tests++;
         if (err !== we[i] || obs !== expv) begin
            fails++; $display("FAIL errors w%0d: got %h err=%b want %h err=%b", i, obs, err, expv, we[i]);
         end
      end
      tests++;
      if ({pixvalid, pix0, pixx} !== {2'b01, 24'h667788, 12'd0}) begin
         fails++; $display("FAIL errors_be_x: got pv=%b p0=%h x=%0d, want 01 667788 0", pixvalid, pix0, pixx);
      end
   endtask

   task automatic test_x_wrap();
      do_reset();
      send(w(8'hFB, 8'h5A, 8'h5A, 8'h5A), 4'b0001);
      for (int i = 1; i <= 3072; i++) begin
         send({$urandom_range(0, 255), 8'h5A, 8'h5A, 8'h5A}, 4'b0000);
         tests++;
         if (obs !== expv) begin
            fails++; $display("FAIL x_wrap w%0d: got %h want %h", i, obs, expv);
         end
      end
      tests++;
      if ({pixvalid, pixx} !== {2'b11, 12'hFFF}) begin
         fails++; $display("FAIL x_wrap_end: got pv=%b x=%h, want 11 fff", pixvalid, pixx);
      end
   endtask

   task automatic test_random();
      logic [7:0]  kt [5];
      logic [31:0] d;
      logic [3:0]  k;
      int          nf;
      kt[0] = 8'hBC; kt[1] = 8'hFB; kt[2] = 8'hFE; kt[3] = 8'hF7; kt[4] = 8'h1C;
      do_reset();
      nf = 0;
      for (int i = 0; i < 2000; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 6) == 0) begin
               k[b] = 1'b1; d[8*b +: 8] = kt[$urandom_range(0, 4)];
            end else begin
               k[b] = 1'b0; d[8*b +: 8] = 8'($urandom_range(0, 255));
            end
         end
         send(d, k);
         tests++;
         if (obs !== expv) begin
            fails++;
            if (nf < 10) $display("FAIL random w%0d d=%h k=%b: got %h want %h", i, d, k, obs, expv);
            nf++;
         end
      end
   endtask

   initial begin
      reset = 1'b1; data = 0; isk = 0;
      model_reset();
      expv = 0;
      test_reset();
      test_basic();
      test_two_pix();
      test_fill();
      test_bs_partial();
      test_vblank();
      test_errors();
      test_x_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dp_sink_unpack.md
Name: dp_sink_unpack

Overview:
- Sink-side main-link depacketizer for the DisplayPort path; the receive-direction counterpart of the source stream packer.
- Consumes one 32-bit word of four 8-bit symbols plus four K flags per clock.
- Tracks blanking, data and fill regions, and reassembles 24-bit RGB pixels from consecutive data bytes.
- Emits up to two pixels per cycle with x/y coordinates, line-start and vertical-blank status, and protocol-error pulses.

Parameters:
- XBITS, 12, width of pixel x counter.
- YBITS, 12, width of line y counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- data  in  32  four symbols; byte 0 (bits 7:0) is first in time, byte 3 last.
- isk  in  4  K flag per byte; isk[i] qualifies data[8i+7:8i].
- pix0  out  24  first pixel completed this word, {R,G,B} with R in bits 23:16.
- pix1  out  24  second pixel completed this word.
- pixvalid  out  2  bit0 = pix0 valid, bit1 = pix1 valid; 2'b10 never occurs.
- pixx  out  XBITS  x coordinate of pix0; pix1 is at pixx+1.
- pixy  out  YBITS  line index of the valid pixels.
- linestart  out  1  one-cycle pulse: a BE was seen in the word.
- vblank  out  1  latched VB-ID bit 0.
- err  out  1  one-cycle pulse: protocol error in the word.

Behaviour:
- Reset (async, active-high): state=BLANK, rem=0, acc=0, x=0, y=0, vblank=1; all outputs 0 except vblank=1.
- Latency: all outputs are registered, 1 cycle after the input word.
- Byte processing: the four bytes are processed strictly in order 0..3 within one cycle as a combinational chain; each byte sees the state and rem left by the previous byte.
- Symbol constants (shared header): BS=8'hBC, BE=8'hFB, FS=8'hFE, FE=8'hF7.
- K-symbol transitions:
  - BS -> BLANK, then next data byte is VB-ID. Error if rem!=0; the partial pixel is dropped and rem=0. If the line had at least one pixel and vblank=0, y increments.
  - BE -> DATA, x=0, linestart=1. Error if state was not BLANK.
  - FS -> FILL. Error if state was not DATA.
  - FE -> DATA. Error if state was not FILL.
  - Any other K symbol -> error, state unchanged.
- Data bytes by state:
  - BLANK_VBID: bit0 loads vblank; when it loads 1, y=0. Then state -> BLANK.
  - BLANK: ignored.
  - FILL: ignored; rem and acc are preserved across the fill, so a pixel may straddle an FS..FE region.
  - DATA: rem 0/1/2 writes acc[23:16]/[15:8]/[7:0]. At rem==2 a pixel completes: it goes to pix0 if no pixel has completed yet this word, else to pix1; rem=0; x increments per pixel. Otherwise rem increments.
- Two pixels per word only occur with rem==2 at word entry and four data bytes.
- pixx reports x before the word's first pixel. pixy reports y at completion.
- x and y wrap modulo 2^XBITS / 2^YBITS with no error.
- vblank=1 does not suppress pixel output.
- err ORs all errors in the word into one pulse.

Decomposition:
- Symbol constants (BS, BE, FS, FE) and state encodings (BLANK, BLANK_VBID, DATA, FILL) go in the shared dport header.
- One natural sub-module: dp_sink_byte, a combinational single-byte step. It maps (state, rem, acc, byte, isk) to (next state, rem, acc, pixel-done, error, BE-seen, VB-ID-load). It is instantiated four times in a chain.

Test Plan:
- Reset, then word {BE,K-flags 0001} followed by words FF00FF_xx data -> linestart pulse; pixels 24'hFF00FF at x=0,1,2...; y=0.
- Entry rem==2 plus four data bytes 11,22,33,44 (previous bytes AA,BB) -> pixvalid=2'b11, pix0=AABB11, pix1=223344.
- Data AA,BB, FS, fill bytes, FE, CC -> single pixel AABBCC; no err; fill bytes not captured.
- BS with rem==1 -> err pulse, partial pixel dropped; next BE line starts clean with pixel at x=0.
- BS followed by VB-ID=01 -> vblank=1, y=0. Then BS with VB-ID=00, BE, 3 lines of pixels -> pixy 0,1,2.
- Unknown K 8'h1C; FS while BLANK; FE while DATA; BE while DATA -> err pulse each; state per transition rules; second BE resets x to 0.
